aes512_cbc_ctrl: RTL

- Multi-block CBC-mode sequencer for the 512-bit AES cores (AES_encryption_512, AES_decryption_512).
- Accepts a message config (mode, key, IV, block count), then streams 512-bit blocks in and out over valid/ready handshakes.
- Drives the core inputs from registers and waits CORE_LAT cycles (multicycle path through the combinational cores) before capturing results.
- Sits between the host/DMA stream and the two core instances; the cores attach through the core_* ports.

---
 rtl/aes512_cbc_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/aes512_cbc_ctrl.sv
// CBC-mode block sequencer for the 512-bit AES encrypt/decrypt cores.
// The cores are combinational; results are captured CORE_LAT cycles after their inputs load.
module aes512_cbc_ctrl #(
  parameter int unsigned CORE_LAT = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [511:0]     key,
  input  logic [511:0]     iv,
  input  logic [CNT_W-1:0] nblocks,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     out_data,
  output logic [511:0]     enc_core_in,
  output logic [511:0]     enc_core_key,
  input  logic [511:0]     enc_core_out,
  output logic [511:0]     dec_core_in,
  output logic [511:0]     dec_core_key,
  input  logic [511:0]     dec_core_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [511:0]     key_q, key_d;
  logic [511:0]     chain_q, chain_d;
  logic [511:0]     in_q, in_d;
  logic [511:0]     out_q, out_d;
  logic [CNT_W-1:0] nblk_q, nblk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       wait_q, wait_d;
  logic             done_q, done_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    key_d   = key_q;
    chain_d = chain_q;
    in_d    = in_q;
    out_d   = out_q;
    nblk_d  = nblk_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          key_d   = key;
          chain_d = iv;
          nblk_d  = nblocks;
          cnt_d   = '0;
          if (nblocks == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          in_d    = in_data;
          wait_d  = 4'(CORE_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          // Decrypt chains on the ciphertext just consumed, encrypt on the fresh result.
          if (mode_q) begin
            out_d   = dec_core_out ^ chain_q;
            chain_d = in_q;
          end else begin
            out_d   = enc_core_out;
            chain_d = enc_core_out;
          end
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == nblk_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      key_q   <= '0;
      chain_q <= '0;
      in_q    <= '0;
      out_q   <= '0;
      nblk_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      in_q    <= in_d;
      out_q   <= out_d;
      nblk_q  <= nblk_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  assign in_ready     = (state_q == StLoad);
  assign out_valid    = (state_q == StOut);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign blk_cnt      = cnt_q;
  assign out_data     = out_q;
  assign enc_core_in  = in_q ^ chain_q;
  assign dec_core_in  = in_q;
  assign enc_core_key = key_q;
  assign dec_core_key = key_q;

endmodule
